// File: rtl/ucode_checkpoint_monitor_if.sv
// rtl/ucode_checkpoint_monitor_if.sv - signal bundle between the microcode sequencer side and the checkpoint monitor
// Ports grouped here: table load (cfg_*), run control (start, limit), retire stream
// (retire, pc_x, pc_f, opcode_x), redirect handshake and the status outputs.
// master = sequencer/bench side, slave = monitor side.
interface ucode_checkpoint_monitor_if #(
    parameter int NCHK = 8,
    parameter int PCW  = 12,
    parameter int OPW  = 112,
    parameter int LIMW = 32
);
    localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;

    logic            cfg_we;
    logic [IW-1:0]   cfg_idx;
    logic [2:0]      cfg_kind;
    logic [PCW-1:0]  cfg_from;
    logic [PCW-1:0]  cfg_to;
    logic [PCW-1:0]  cfg_target;
    logic [LIMW-1:0] limit;
    logic            start;
    logic            retire;
    logic [PCW-1:0]  pc_x;
    logic [PCW-1:0]  pc_f;
    logic [OPW-1:0]  opcode_x;
    logic            redirect_valid;
    logic [PCW-1:0]  redirect_pc;
    logic            redirect_ack;
    logic            hit_valid;
    logic [IW-1:0]   hit_idx;
    logic [NCHK-1:0] hit_mask;
    logic [IW:0]     pass_count;
    logic            done;
    logic [1:0]      status;
    logic [LIMW-1:0] cycles;

    modport master (
        output cfg_we, cfg_idx, cfg_kind, cfg_from, cfg_to, cfg_target,
        output limit, start, retire, pc_x, pc_f, opcode_x, redirect_ack,
        input  redirect_valid, redirect_pc, hit_valid, hit_idx, hit_mask,
        input  pass_count, done, status, cycles
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_kind, cfg_from, cfg_to, cfg_target,
        input  limit, start, retire, pc_x, pc_f, opcode_x, redirect_ack,
        output redirect_valid, redirect_pc, hit_valid, hit_idx, hit_mask,
        output pass_count, done, status, cycles
    );
endinterface

// File: rtl/ucode_checkpoint_monitor.sv
// rtl/ucode_checkpoint_monitor.sv - checkpoint monitor for microcode self-tests
// Ports: clk, reset (async, active-low), bus (slave modport of ucode_checkpoint_monitor_if).
// Watches retired micro-instructions against a loadable checkpoint table, reports hits,
// requests sequencer redirects on loop-exit jumps, and ends the run on fail/finish/timeout.
module ucode_checkpoint_monitor #(
    parameter int NCHK = 8,
    parameter int PCW  = 12,
    parameter int OPW  = 112,
    parameter int LIMW = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    ucode_checkpoint_monitor_if.slave   bus
);
    localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;

    localparam logic [2:0] K_OFF    = 3'd0;
    localparam logic [2:0] K_CONT   = 3'd1;
    localparam logic [2:0] K_JUMP   = 3'd2;
    localparam logic [2:0] K_FAIL   = 3'd3;
    localparam logic [2:0] K_FINISH = 3'd4;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIR, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      kind_q [NCHK];
    logic [PCW-1:0]  from_q [NCHK];
    logic [PCW-1:0]  to_q   [NCHK];
    logic [PCW-1:0]  tgt_q  [NCHK];

    logic            hit_valid_q, hit_valid_d;
    logic [IW-1:0]   hit_idx_q, hit_idx_d;
    logic [NCHK-1:0] hit_mask_q, hit_mask_d;
    logic [IW:0]     pass_q, pass_d;
    logic            done_q, done_d;
    logic [1:0]      status_q, status_d;
    logic [LIMW-1:0] cycles_q, cycles_d;
    logic [LIMW-1:0] limit_q, limit_d;
    logic            rv_q, rv_d;
    logic [PCW-1:0]  rpc_q, rpc_d;

    // Table is writable only while idle so a running test sees a stable table.
    logic tbl_we;
    assign tbl_we = bus.cfg_we && (state_q == S_IDLE) && (int'(bus.cfg_idx) < NCHK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCHK; i++) begin
                kind_q[i] <= K_OFF;
                from_q[i] <= '0;
                to_q[i]   <= '0;
                tgt_q[i]  <= '0;
            end
        end else if (tbl_we) begin
            kind_q[bus.cfg_idx] <= bus.cfg_kind;
            from_q[bus.cfg_idx] <= bus.cfg_from;
            to_q[bus.cfg_idx]   <= bus.cfg_to;
            tgt_q[bus.cfg_idx]  <= bus.cfg_target;
        end
    end

    // CONT entries recognise the loop-continue microinstruction: sequencer field 14,
    // map field 0, and the branch address field equal to the entry label.
    logic           cont_op;
    logic [PCW-1:0] a_field;
    assign cont_op = (bus.opcode_x[OPW-1:OPW-4] == 4'd14) && (bus.opcode_x[OPW-17:OPW-18] == 2'd0);
    assign a_field = PCW'(bus.opcode_x[OPW-5:OPW-16]);

    logic          fail_hit, fin_hit, jump_hit, cont_hit;
    logic [IW-1:0] fail_idx, fin_idx, jump_idx, cont_idx;

    // Scan from the top so the lowest matching index of each kind is left standing.
    always_comb begin
        fail_hit = 1'b0; fin_hit = 1'b0; jump_hit = 1'b0; cont_hit = 1'b0;
        fail_idx = '0;   fin_idx = '0;   jump_idx = '0;   cont_idx = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            case (kind_q[i])
                K_CONT:   if (cont_op && a_field == from_q[i]) begin
                              cont_hit = 1'b1; cont_idx = IW'(i);
                          end
                K_JUMP:   if (bus.pc_x == from_q[i] && bus.pc_f == to_q[i]) begin
                              jump_hit = 1'b1; jump_idx = IW'(i);
                          end
                K_FAIL:   if (bus.pc_x == from_q[i]) begin
                              fail_hit = 1'b1; fail_idx = IW'(i);
                          end
                K_FINISH: if (bus.pc_x == from_q[i]) begin
                              fin_hit = 1'b1; fin_idx = IW'(i);
                          end
                default:  ;
            endcase
        end
    end

    logic          win_hit, win_counts;
    logic [IW-1:0] win_idx;
    assign win_hit    = fail_hit | fin_hit | jump_hit | cont_hit;
    assign win_idx    = fail_hit ? fail_idx : fin_hit ? fin_idx : jump_hit ? jump_idx : cont_idx;
    assign win_counts = !fail_hit && !fin_hit;

    logic            timeout;
    logic [LIMW-1:0] cyc_inc;
    assign timeout = (limit_q != '0) && (cycles_q == limit_q - LIMW'(1));
    assign cyc_inc = (&cycles_q) ? cycles_q : cycles_q + LIMW'(1);

    always_comb begin
        state_d     = state_q;
        hit_valid_d = 1'b0;
        hit_idx_d   = hit_idx_q;
        hit_mask_d  = hit_mask_q;
        pass_d      = pass_q;
        done_d      = done_q;
        status_d    = status_q;
        cycles_d    = cycles_q;
        limit_d     = limit_q;
        rv_d        = rv_q;
        rpc_d       = rpc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    hit_mask_d = '0;
                    pass_d     = '0;
                    cycles_d   = '0;
                    status_d   = ST_NONE;
                    done_d     = 1'b0;
                    limit_d    = bus.limit;
                end
            end
            S_RUN: begin
                cycles_d = cyc_inc;
                if (bus.retire && win_hit) begin
                    hit_valid_d         = 1'b1;
                    hit_idx_d           = win_idx;
                    hit_mask_d[win_idx] = 1'b1;
                    if (win_counts && !hit_mask_q[win_idx])
                        pass_d = pass_q + (IW+1)'(1);
                end
                // Fail/finish beat a timeout on the same edge; a timeout beats a jump.
                if (bus.retire && fail_hit) begin
                    state_d = S_DONE; done_d = 1'b1; status_d = ST_FAIL;
                end else if (bus.retire && fin_hit) begin
                    state_d = S_DONE; done_d = 1'b1; status_d = ST_PASS;
                end else if (timeout) begin
                    state_d = S_DONE; done_d = 1'b1; status_d = ST_TIMEOUT;
                end else if (bus.retire && jump_hit) begin
                    state_d = S_REDIR; rv_d = 1'b1; rpc_d = tgt_q[jump_idx];
                end
            end
            S_REDIR: begin
                cycles_d = cyc_inc;
                if (timeout) begin
                    state_d = S_DONE; done_d = 1'b1; status_d = ST_TIMEOUT; rv_d = 1'b0;
                end else if (bus.redirect_ack) begin
                    state_d = S_RUN; rv_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            hit_mask_q  <= '0;
            pass_q      <= '0;
            done_q      <= 1'b0;
            status_q    <= ST_NONE;
            cycles_q    <= '0;
            limit_q     <= '0;
            rv_q        <= 1'b0;
            rpc_q       <= '0;
        end else begin
            state_q     <= state_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
            hit_mask_q  <= hit_mask_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
            limit_q     <= limit_d;
            rv_q        <= rv_d;
            rpc_q       <= rpc_d;
        end
    end

    assign bus.hit_valid      = hit_valid_q;
    assign bus.hit_idx        = hit_idx_q;
    assign bus.hit_mask       = hit_mask_q;
    assign bus.pass_count     = pass_q;
    assign bus.done           = done_q;
    assign bus.status         = status_q;
    assign bus.cycles         = cycles_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
endmodule
